icx_vtiming_gen: RTL and testbench
==================================

Name: icx_vtiming_gen

Overview:
- Parametrised, triggerable frame-timing generator for the ICX interline CCD. It is the next generation of the fixed free-running counter/pulse generator.
- Sequences five phases per frame: idle, readout-transfer (init), fast-dump lines, gap, normal readout lines.
- Produces the vertical-clock phase controls, readout high-voltage pulses, and horizontal blank/clamp/sub strobes for the level shifters and AFE.
- Adds start/busy/done handshake, continuous mode, abort, line/frame status, and runtime line count.

Parameters:
- CW, 12, width of position and line counters
- INIT_PERIOD, 3340, cycles in the init (readout-transfer) phase
- FAST_PERIOD, 352, cycles per fast-dump line
- FAST_COUNT, 13, number of fast-dump lines
- GAP_PERIOD, 8, cycles in the gap phase
- LINE_PERIOD, 1132, cycles per normal line
- HBLANK_END, 356, hpos at which hblank deasserts
- CLPOB_LO, 359, clpob asserted for hpos in (CLPOB_LO, CLPOB_HI]
- CLPOB_HI, 386, see CLPOB_LO
- THSUB_LO, 240, thsub asserted for hpos in (THSUB_LO, THSUB_HI]
- THSUB_HI, 294, see THSUB_LO

Ports:
- clk  in  1  system clock (54 MHz)
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle frame request; honoured only in IDLE
- cont  in  1  continuous mode: re-enter INIT after DONE without start
- abort  in  1  synchronous abort; returns to IDLE next cycle
- num_lines  in  CW  normal readout lines per frame; 0 treated as 1
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse in DONE
- line_valid  out  1  high in NORMAL while hpos > HBLANK_END
- line_idx  out  CW  current normal-line index, 0-based
- frame_cnt  out  8  completed-frame count, wraps 255->0
- xvt1, xvt2, xvt3, xvt4  out  1 each  1 = -7 V, 0 = 0 V
- rvt2, rvt3  out  1 each  1 = +12 V readout pulse
- hblank, thsub, cob  out  1 each  horizontal strobes

Behaviour:
- States: IDLE, INIT, FAST, GAP, NORMAL, DONE.
- `pos` is zeroed on every phase/line entry and increments by 1 per cycle.
- Every output is registered: it reflects the (state, pos) of the previous cycle, i.e. 1-cycle latency.
- Transitions:
  - IDLE->INIT on start or cont.
  - INIT->FAST at pos==INIT_PERIOD-1.
  - FAST: at pos==FAST_PERIOD-1, fcnt++. The last line (fcnt==FAST_COUNT-1) goes to GAP.
  - GAP->NORMAL at pos==GAP_PERIOD-1.
  - NORMAL: at pos==LINE_PERIOD-1, line_idx++. If line_idx==max(num_lines,1)-1, go to DONE.
  - DONE (one cycle): frame_cnt++, frame_done=1, then INIT if cont else IDLE.
- num_lines is sampled on INIT entry; mid-frame changes are ignored.
- Pulse windows, with p = pos:
  - INIT: xvt1=1; xvt4=0 for p in (1128,2748], else 1; xvt2=xvt3=0; rvt2 for p in (2656,2818]; rvt3 for p in (2678,2840].
  - FAST: xvt1=0 for p in [89,308]; xvt2=1 in (44,176]; xvt3=1 in (132,264]; xvt4=1 in (220,352]. Outside each window the opposite level.
  - GAP: xvt1=1, xvt4=1, xvt2=xvt3=0.
  - NORMAL: xvt1=0 in [92,311]; xvt4=0 in (3,223]; xvt2=1 in (47,179]; xvt3=1 in (135,267]. Outside each window the opposite level.
  - IDLE/DONE: same levels as GAP; rvt2=rvt3=0.
- Horizontal strobes are valid in NORMAL only, using hpos=pos:
  - hblank=1 for pos<=HBLANK_END.
  - thsub and cob per their (LO, HI] windows.
  - Outside NORMAL: hblank=1, thsub=0, cob=0.
- Reset values: state IDLE; pos, line_idx, frame_cnt = 0; xvt1=xvt4=1; xvt2=xvt3=0; rvt2=rvt3=0; hblank=1; thsub=cob=0; busy=frame_done=line_valid=0.
- Simultaneous events:
  - abort beats start and all transitions.
  - abort yields IDLE outputs next cycle, no frame_done, and frame_cnt unchanged.
  - start while busy is ignored.
  - start and cont both high in IDLE give a single entry.
- Async reset mid-frame forces reset values immediately; the next frame needs start or cont.
- Counters are CW bits wide. Parameters must satisfy every PERIOD <= 2^CW; no wrap occurs inside a phase.

Optional Feature:
- Macro ICX_VBIN2_EN.
- When defined:
  - Each NORMAL line emits two vertical transfer sequences: the window set at pos and again at pos-LINE_PERIOD/2, for 2x vertical binning.
  - line_idx counts binned lines.
  - Frame ends after max(num_lines,1) binned lines.
- When undefined: a single sequence per line, and the logic is absent.

Test Plan:
- Reset low then high, no start, 5000 cycles -> stays IDLE; busy=0, xvt1=1, xvt4=1, hblank=1.
- start pulse, cont=0, num_lines=4 -> busy rises next cycle.
  - rvt2 high exactly 162 cycles, from INIT p=2657.
  - 13 fast lines of 352 cycles, then 8-cycle gap.
  - 4 lines of 1132 cycles; frame_done single pulse; frame_cnt=1; back to IDLE.
- cont=1, num_lines=2, run 3 frames -> frame_done pulses spaced 3340+13*352+8+2*1132+1=10189 cycles; frame_cnt=3.
- abort asserted at NORMAL line 1, pos 500 -> next cycle IDLE outputs; frame_done never pulses; frame_cnt unchanged.
- num_lines=0 -> exactly 1 normal line; num_lines changed during FAST -> no effect until next frame.
- NORMAL line checks:
  - cob high for hpos 360..386 (27 cycles).
  - thsub high for 241..294.
  - line_valid low through hpos 356, high from 357.
  - With ICX_VBIN2_EN, xvt2 pulses twice per line, 566 cycles apart.

Source files
------------

// File: rtl/icx_vtiming_gen_if.sv
// Control/status and level-shifter strobe bundle for icx_vtiming_gen.
// The master side issues frame requests; the slave side is the timing generator.
interface icx_vtiming_gen_if #(
    parameter int CW = 12
);
    logic          start;
    logic          cont;
    logic          abort;
    logic [CW-1:0] num_lines;
    logic          busy;
    logic          frame_done;
    logic          line_valid;
    logic [CW-1:0] line_idx;
    logic [7:0]    frame_cnt;
    logic          xvt1;
    logic          xvt2;
    logic          xvt3;
    logic          xvt4;
    logic          rvt2;
    logic          rvt3;
    logic          hblank;
    logic          thsub;
    logic          cob;

    modport master (
        output start, cont, abort, num_lines,
        input  busy, frame_done, line_valid, line_idx, frame_cnt,
        input  xvt1, xvt2, xvt3, xvt4, rvt2, rvt3, hblank, thsub, cob
    );

    modport slave (
        input  start, cont, abort, num_lines,
        output busy, frame_done, line_valid, line_idx, frame_cnt,
        output xvt1, xvt2, xvt3, xvt4, rvt2, rvt3, hblank, thsub, cob
    );
endinterface

// File: rtl/icx_vtiming_gen.sv
// Triggerable ICX interline CCD frame-timing generator: IDLE/INIT/FAST/GAP/NORMAL/DONE.
// Define ICX_VBIN2_EN to repeat the vertical transfer sequence at half-line for 2x binning.
module icx_vtiming_gen #(
    parameter int CW          = 12,
    parameter int INIT_PERIOD = 3340,
    parameter int FAST_PERIOD = 352,
    parameter int FAST_COUNT  = 13,
    parameter int GAP_PERIOD  = 8,
    parameter int LINE_PERIOD = 1132,
    parameter int HBLANK_END  = 356,
    parameter int CLPOB_LO    = 359,
    parameter int CLPOB_HI    = 386,
    parameter int THSUB_LO    = 240,
    parameter int THSUB_HI    = 294
) (
    input  logic             clk,
    input  logic             reset,
    icx_vtiming_gen_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_FAST   = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_NORMAL = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_PERIOD - 1);
    localparam logic [CW-1:0] FAST_LAST = CW'(FAST_PERIOD - 1);
    localparam logic [CW-1:0] FCNT_LAST = CW'(FAST_COUNT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_PERIOD - 1);
    localparam logic [CW-1:0] LINE_LAST = CW'(LINE_PERIOD - 1);
    localparam logic [CW-1:0] HB_END    = CW'(HBLANK_END);

    logic [2:0]    state;
    logic [CW-1:0] pos;
    logic [CW-1:0] fcnt;
    logic [CW-1:0] lidx;
    logic [CW-1:0] nlines;
    logic [CW-1:0] nl_in;
    logic [CW-1:0] pos_inc;

    function automatic logic in_oc(input logic [CW-1:0] p, input int lo, input int hi);
        return (p > CW'(lo)) && (p <= CW'(hi));
    endfunction

    function automatic logic in_cc(input logic [CW-1:0] p, input int lo, input int hi);
        return (p >= CW'(lo)) && (p <= CW'(hi));
    endfunction

    assign nl_in   = (bus.num_lines == '0) ? CW'(1) : bus.num_lines;
    assign pos_inc = pos + CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            pos    <= '0;
            fcnt   <= '0;
            lidx   <= '0;
            nlines <= CW'(1);
        end else if (bus.abort) begin
            state <= S_IDLE;
            pos   <= '0;
            fcnt  <= '0;
            lidx  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start || bus.cont) begin
                        state  <= S_INIT;
                        pos    <= '0;
                        lidx   <= '0;
                        nlines <= nl_in;
                    end
                end
                S_INIT: begin
                    if (pos == INIT_LAST) begin
                        state <= S_FAST;
                        pos   <= '0;
                        fcnt  <= '0;
                    end else begin
                        pos <= pos_inc;
                    end
                end
                S_FAST: begin
                    if (pos == FAST_LAST) begin
                        pos <= '0;
                        if (fcnt == FCNT_LAST) state <= S_GAP;
                        else                   fcnt  <= fcnt + CW'(1);
                    end else begin
                        pos <= pos_inc;
                    end
                end
                S_GAP: begin
                    if (pos == GAP_LAST) begin
                        state <= S_NORMAL;
                        pos   <= '0;
                    end else begin
                        pos <= pos_inc;
                    end
                end
                S_NORMAL: begin
                    if (pos == LINE_LAST) begin
                        pos <= '0;
                        if (lidx == nlines - CW'(1)) state <= S_DONE;
                        else                         lidx  <= lidx + CW'(1);
                    end else begin
                        pos <= pos_inc;
                    end
                end
                S_DONE: begin
                    pos <= '0;
                    if (bus.cont) begin
                        state  <= S_INIT;
                        lidx   <= '0;
                        nlines <= nl_in;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage p0: decode (state, pos) into strobe levels; abort forces the idle decode.
    logic [2:0]    eff;
    logic [CW-1:0] vp;
    logic xvt1_p0, xvt2_p0, xvt3_p0, xvt4_p0, rvt2_p0, rvt3_p0;
    logic hblank_p0, thsub_p0, cob_p0, lv_p0;

`ifdef ICX_VBIN2_EN
    localparam logic [CW-1:0] HALF_LINE = CW'(LINE_PERIOD / 2);
    // All vertical windows close before the half-line, so folding pos replays them once more.
    assign vp = (pos >= HALF_LINE) ? pos - HALF_LINE : pos;
`else
    assign vp = pos;
`endif

    always_comb begin
        eff       = bus.abort ? S_IDLE : state;
        xvt1_p0   = 1'b1;
        xvt2_p0   = 1'b0;
        xvt3_p0   = 1'b0;
        xvt4_p0   = 1'b1;
        rvt2_p0   = 1'b0;
        rvt3_p0   = 1'b0;
        hblank_p0 = 1'b1;
        thsub_p0  = 1'b0;
        cob_p0    = 1'b0;
        lv_p0     = 1'b0;
        case (eff)
            S_INIT: begin
                xvt4_p0 = !in_oc(pos, 1128, 2748);
                rvt2_p0 = in_oc(pos, 2656, 2818);
                rvt3_p0 = in_oc(pos, 2678, 2840);
            end
            S_FAST: begin
                xvt1_p0 = !in_cc(pos, 89, 308);
                xvt2_p0 = in_oc(pos, 44, 176);
                xvt3_p0 = in_oc(pos, 132, 264);
                xvt4_p0 = in_oc(pos, 220, 352);
            end
            S_NORMAL: begin
                xvt1_p0   = !in_cc(vp, 92, 311);
                xvt4_p0   = !in_oc(vp, 3, 223);
                xvt2_p0   = in_oc(vp, 47, 179);
                xvt3_p0   = in_oc(vp, 135, 267);
                hblank_p0 = (pos <= HB_END);
                lv_p0     = (pos > HB_END);
                thsub_p0  = in_oc(pos, THSUB_LO, THSUB_HI);
                cob_p0    = in_oc(pos, CLPOB_LO, CLPOB_HI);
            end
            default: ;
        endcase
    end

    // Stage p1: registered outputs, one cycle behind (state, pos).
    logic xvt1_p1, xvt2_p1, xvt3_p1, xvt4_p1, rvt2_p1, rvt3_p1;
    logic hblank_p1, thsub_p1, cob_p1;
    logic busy_p1, done_p1, lv_p1;
    logic [CW-1:0] lidx_p1;
    logic [7:0]    fcnt_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xvt1_p1   <= 1'b1;
            xvt2_p1   <= 1'b0;
            xvt3_p1   <= 1'b0;
            xvt4_p1   <= 1'b1;
            rvt2_p1   <= 1'b0;
            rvt3_p1   <= 1'b0;
            hblank_p1 <= 1'b1;
            thsub_p1  <= 1'b0;
            cob_p1    <= 1'b0;
            busy_p1   <= 1'b0;
            done_p1   <= 1'b0;
            lv_p1     <= 1'b0;
            lidx_p1   <= '0;
            fcnt_p1   <= '0;
        end else begin
            xvt1_p1   <= xvt1_p0;
            xvt2_p1   <= xvt2_p0;
            xvt3_p1   <= xvt3_p0;
            xvt4_p1   <= xvt4_p0;
            rvt2_p1   <= rvt2_p0;
            rvt3_p1   <= rvt3_p0;
            hblank_p1 <= hblank_p0;
            thsub_p1  <= thsub_p0;
            cob_p1    <= cob_p0;
            busy_p1   <= (eff != S_IDLE);
            done_p1   <= (eff == S_DONE);
            lv_p1     <= lv_p0;
            lidx_p1   <= bus.abort ? '0 : lidx;
            if (eff == S_DONE) fcnt_p1 <= fcnt_p1 + 8'd1;
        end
    end

    assign bus.xvt1       = xvt1_p1;
    assign bus.xvt2       = xvt2_p1;
    assign bus.xvt3       = xvt3_p1;
    assign bus.xvt4       = xvt4_p1;
    assign bus.rvt2       = rvt2_p1;
    assign bus.rvt3       = rvt3_p1;
    assign bus.hblank     = hblank_p1;
    assign bus.thsub      = thsub_p1;
    assign bus.cob        = cob_p1;
    assign bus.busy       = busy_p1;
    assign bus.frame_done = done_p1;
    assign bus.line_valid = lv_p1;
    assign bus.line_idx   = lidx_p1;
    assign bus.frame_cnt  = fcnt_p1;
endmodule

// File: tb/tb_icx_vtiming_gen.sv
// Randomised bench for icx_vtiming_gen against a frame-timeline reference model.
// The model tracks elapsed cycles since frame start and derives phase/pos arithmetically.
module tb_icx_vtiming_gen;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    icx_vtiming_gen_if #(.CW(12)) bus ();
    icx_vtiming_gen dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    localparam int T_INIT    = 3340;
    localparam int T_FAST    = 352 * 13;
    localparam int T_LINE    = 1132;
    localparam int NORM_BASE = T_INIT + T_FAST + 8;
    localparam int AB_POS    = NORM_BASE + T_LINE + 500;
`ifdef ICX_VBIN2_EN
    localparam bit VBIN = 1'b1;
    localparam int X2_PER_LINE = 2;
    localparam int X2_LAST_GAP = 566;
`else
    localparam bit VBIN = 1'b0;
    localparam int X2_PER_LINE = 1;
    localparam int X2_LAST_GAP = 1132;
`endif
    localparam logic [8:0] VT_IDLE = 9'b1_0_0_1_0_0_1_0_0;

    int checks   = 0;
    int failures = 0;

    bit         m_act = 1'b0;
    int         m_e = 0, m_n = 1, m_li_idle = 0;
    logic [7:0] m_fc = 8'd0;

    int cyc = 0, n_rvt2, n_cob, n_thsub, n_lv, n_fd, n_x2, last_fd, last_x2, x2_gap;
    int rvt2_first, busy_rise;
    int fd_gaps[$];
    logic prev_x2 = 1'b0, prev_rvt2 = 1'b0, prev_busy = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit oc(input int p, input int lo, input int hi);
        return (p > lo) && (p <= hi);
    endfunction

    function automatic bit cc(input int p, input int lo, input int hi);
        return (p >= lo) && (p <= hi);
    endfunction

    function automatic bit voc(input int p, input int lo, input int hi);
        return oc(p, lo, hi) || (VBIN && p >= T_LINE / 2 && oc(p - T_LINE / 2, lo, hi));
    endfunction

    function automatic bit vcc(input int p, input int lo, input int hi);
        return cc(p, lo, hi) || (VBIN && p >= T_LINE / 2 && cc(p - T_LINE / 2, lo, hi));
    endfunction

    // vt = {xvt1, xvt2, xvt3, xvt4, rvt2, rvt3, hblank, thsub, cob}
    task automatic predict(input bit act, input int e, input int n, output logic [8:0] vt,
                           output bit eb, output bit elv, output bit efd, output int eli);
        int p;
        vt = VT_IDLE; eb = act; elv = 1'b0; efd = 1'b0; eli = 0;
        if (!act) return;
        if (e < T_INIT) begin
            vt[5] = !oc(e, 1128, 2748);
            vt[4] = oc(e, 2656, 2818);
            vt[3] = oc(e, 2678, 2840);
        end else if (e < T_INIT + T_FAST) begin
            p = (e - T_INIT) % 352;
            vt[8] = !cc(p, 89, 308);
            vt[7] = oc(p, 44, 176);
            vt[6] = oc(p, 132, 264);
            vt[5] = oc(p, 220, 352);
        end else if (e < NORM_BASE) begin
            vt = VT_IDLE;
        end else if (e < NORM_BASE + T_LINE * n) begin
            p = (e - NORM_BASE) % T_LINE;
            eli = (e - NORM_BASE) / T_LINE;
            vt[8] = !vcc(p, 92, 311);
            vt[7] = voc(p, 47, 179);
            vt[6] = voc(p, 135, 267);
            vt[5] = !voc(p, 3, 223);
            vt[2] = (p <= 356);
            vt[1] = oc(p, 240, 294);
            vt[0] = oc(p, 359, 386);
            elv = (p > 356);
        end else begin
            efd = 1'b1;
            eli = n - 1;
        end
    endtask

    task automatic step(input bit s, input bit c, input bit a, input int nl);
        logic [8:0] evt;
        bit eb, elv, efd;
        int eli;
        @(negedge clk);
        bus.start = s; bus.cont = c; bus.abort = a; bus.num_lines = 12'(nl);
        @(posedge clk);
        #1;
        cyc++;
        if (a) begin
            evt = VT_IDLE; eb = 1'b0; elv = 1'b0; efd = 1'b0; eli = 0;
            m_act = 1'b0; m_e = 0; m_li_idle = 0;
        end else begin
            predict(m_act, m_e, m_n, evt, eb, elv, efd, eli);
            if (!m_act) eli = m_li_idle;
            if (efd) m_fc = m_fc + 8'd1;
            if (!m_act) begin
                if (s || c) begin m_act = 1'b1; m_e = 0; m_n = (nl == 0) ? 1 : nl; end
            end else if (m_e == NORM_BASE + T_LINE * m_n) begin
                if (c) begin m_e = 0; m_n = (nl == 0) ? 1 : nl; end
                else begin m_act = 1'b0; m_li_idle = m_n - 1; end
            end else begin
                m_e++;
            end
        end
        check_val("vt", 32'({bus.xvt1, bus.xvt2, bus.xvt3, bus.xvt4, bus.rvt2, bus.rvt3,
                              bus.hblank, bus.thsub, bus.cob}), 32'(evt));
        check_val("status", 32'({bus.busy, bus.frame_done, bus.line_valid}), 32'({eb, efd, elv}));
        check_val("line_idx", 32'(bus.line_idx), 32'(eli));
        check_val("frame_cnt", 32'(bus.frame_cnt), 32'(m_fc));
        if (bus.rvt2) n_rvt2++;
        if (bus.rvt2 && !prev_rvt2) rvt2_first = cyc;
        if (bus.busy && !prev_busy) busy_rise = cyc;
        if (bus.cob) n_cob++;
        if (bus.thsub) n_thsub++;
        if (bus.line_valid) n_lv++;
        if (bus.frame_done) begin n_fd++; fd_gaps.push_back(cyc - last_fd); last_fd = cyc; end
        if (bus.xvt2 && !prev_x2) begin n_x2++; x2_gap = cyc - last_x2; last_x2 = cyc; end
        prev_x2 = bus.xvt2; prev_rvt2 = bus.rvt2; prev_busy = bus.busy;
    endtask

    task automatic clr_mon();
        n_rvt2 = 0; n_cob = 0; n_thsub = 0; n_lv = 0; n_fd = 0; n_x2 = 0;
        last_fd = cyc; last_x2 = cyc; x2_gap = 0; rvt2_first = 0; busy_rise = 0;
        fd_gaps.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_vt"}, 32'({bus.xvt1, bus.xvt2, bus.xvt3, bus.xvt4, bus.rvt2, bus.rvt3,
                                     bus.hblank, bus.thsub, bus.cob}), 32'(VT_IDLE));
        check_val({tag, "_st"}, 32'({bus.busy, bus.frame_done, bus.line_valid}), 32'd0);
        check_val({tag, "_cnt"}, 32'({bus.line_idx, bus.frame_cnt}), 32'd0);
    endtask

    initial begin
        int start_cyc;
        bit cont_r;
        bus.start = 1'b0; bus.cont = 1'b0; bus.abort = 1'b0; bus.num_lines = '0;
        #12;
        check_reset_vals("por");
        @(negedge clk) reset = 1'b1;

        // No request: stays idle regardless of num_lines.
        clr_mon();
        repeat (5000) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 7));
        check_val("idle_busy_rise", 32'(busy_rise), 32'd0);

        // Single frame, 4 lines; later num_lines changes must be ignored.
        clr_mon();
        step(1'b1, 1'b0, 1'b0, 4);
        start_cyc = cyc;
        for (int i = 0; i < 13000 && n_fd == 0; i++) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 15));
        repeat (4) step(1'b0, 1'b0, 1'b0, 4);
        check_val("f1_done_cnt", 32'(n_fd), 32'd1);
        check_val("f1_busy_rise", 32'(busy_rise - start_cyc), 32'd1);
        check_val("f1_rvt2_len", 32'(n_rvt2), 32'd162);
        check_val("f1_rvt2_pos", 32'(rvt2_first - busy_rise), 32'd2657);
        check_val("f1_cob", 32'(n_cob), 32'(4 * 27));
        check_val("f1_thsub", 32'(n_thsub), 32'(4 * 54));
        check_val("f1_lv", 32'(n_lv), 32'(4 * 775));
        check_val("f1_x2_rises", 32'(n_x2), 32'(13 + 4 * X2_PER_LINE));
        check_val("f1_x2_gap", 32'(x2_gap), 32'(X2_LAST_GAP));
        check_val("f1_frame_cnt", 32'(bus.frame_cnt), 32'd1);

        // Async reset in the middle of a frame; afterwards it must wait for a new request.
        step(1'b1, 1'b0, 1'b0, 3);
        repeat (4000) step(1'b0, 1'b0, 1'b0, 3);
        #2 reset = 1'b0;
        #1 check_reset_vals("areset");
        m_act = 1'b0; m_e = 0; m_fc = 8'd0; m_li_idle = 0;
        @(negedge clk) reset = 1'b1;
        repeat (20) step(1'b0, 1'b0, 1'b0, 3);

        // Continuous mode, 2 lines per frame, three frames.
        clr_mon();
        for (int i = 0; i < 35000 && n_fd < 3; i++) step(1'b0, 1'b1, 1'b0, 2);
        check_val("cont_done_cnt", 32'(n_fd), 32'd3);
        check_val("cont_gap1", 32'((fd_gaps.size() > 1) ? fd_gaps[1] : 0), 32'd10189);
        check_val("cont_gap2", 32'((fd_gaps.size() > 2) ? fd_gaps[2] : 0), 32'd10189);
        check_val("cont_frame_cnt", 32'(bus.frame_cnt), 32'd3);

        // Abort at NORMAL line 1, pos 500 (abort also beats a simultaneous start).
        for (int i = 0; i < 12000 && !(m_act && m_e == AB_POS); i++) step(1'b0, 1'b1, 1'b0, 2);
        check_val("abort_reached", 32'(m_act && m_e == AB_POS), 32'd1);
        step(1'b1, 1'b0, 1'b1, 2);
        check_val("abort_busy", 32'(bus.busy), 32'd0);
        repeat (1200) step(1'b0, 1'b0, 1'b0, 2);
        check_val("abort_no_done", 32'(n_fd), 32'd3);
        check_val("abort_frame_cnt", 32'(bus.frame_cnt), 32'd3);

        // num_lines = 0 acts as 1; raising it after INIT entry has no effect.
        clr_mon();
        step(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 9500 && n_fd == 0; i++) step(1'b0, 1'b0, 1'b0, 3);
        repeat (3) step(1'b0, 1'b0, 1'b0, 3);
        check_val("nl0_done", 32'(n_fd), 32'd1);
        check_val("nl0_lv", 32'(n_lv), 32'd775);
        check_val("nl0_cob", 32'(n_cob), 32'd27);

        // Random requests, continuous toggles and rare aborts.
        cont_r = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 3999) == 0) cont_r = !cont_r;
            step(($urandom_range(0, 149) == 0), cont_r, ($urandom_range(0, 2499) == 0),
                 $urandom_range(0, 2));
        end
        step(1'b0, 1'b0, 1'b1, 0);
        check_val("end_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
